// File: rtl/uart_msg_sender_pkg.sv
// Shared definitions for the UART message sender: ASCII line terminators and FSM encoding.
package uart_msg_sender_pkg;

    localparam logic [7:0] AsciiCr = 8'h0D;
    localparam logic [7:0] AsciiLf = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StCr,
        StLf,
        StEnd,
        StGap
    } state_e;

    // State that follows the payload (or replaces it when the payload is empty).
    function automatic state_e payload_exit(input bit append_crlf);
        return append_crlf ? StCr : StEnd;
    endfunction

endpackage

// File: rtl/uart_msg_sender_buf.sv
// Message buffer: simple dual-port byte RAM with synchronous write and synchronous read.
module uart_msg_sender_buf
    import uart_msg_sender_pkg::*;
#(
    parameter int unsigned Depth = 32,
    parameter int unsigned AddrW = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [Depth];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_msg_sender.sv
// Streams a buffered message (plus optional CR/LF) over a valid/ready byte port,
// with optional auto-repeat after an idle gap and abort at byte boundaries.
module uart_msg_sender
    import uart_msg_sender_pkg::*;
#(
    parameter int unsigned MsgMaxLen  = 32,
    parameter int unsigned LenW       = 6,
    parameter bit          AppendCrlf = 1'b1,
    parameter int unsigned GapW       = 24
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            wr_en_i,
    input  logic [LenW-1:0] wr_addr_i,
    input  logic [7:0]      wr_data_i,
    input  logic [LenW-1:0] msg_len_i,
    input  logic            start_i,
    input  logic            repeat_en_i,
    input  logic [GapW-1:0] gap_cycles_i,
    input  logic            abort_i,
    output logic [7:0]      tx_data_o,
    output logic            tx_data_valid_o,
    input  logic            tx_data_ready_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            aborted_o
);

    localparam int unsigned     BufAw  = $clog2(MsgMaxLen);
    localparam logic [LenW-1:0] MaxLen = LenW'(MsgMaxLen);

    state_e          state_q, state_d;
    logic [LenW-1:0] idx_q, idx_d;
    logic [LenW-1:0] len_q, len_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            abort_q, abort_d;
    logic            aborted_q, aborted_d;

    logic [7:0]      rd_data;
    logic [LenW-1:0] eff_len;
    logic            abort_pend;
    logic            xfer;
    logic            last_byte;
    logic            buf_we;
    logic            buf_re;

    assign eff_len    = (msg_len_i > MaxLen) ? MaxLen : msg_len_i;
    assign abort_pend = abort_q | abort_i;
    assign xfer       = tx_data_valid_o & tx_data_ready_i;
    assign last_byte  = (idx_q == len_q - LenW'(1));
    // Buffer is frozen while a message is in flight.
    assign buf_we     = wr_en_i & (state_q == StIdle) & (wr_addr_i < MaxLen);
    assign buf_re     = (state_q == StFetch);

    uart_msg_sender_buf #(
        .Depth (MsgMaxLen),
        .AddrW (BufAw)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (wr_addr_i[BufAw-1:0]),
        .wdata_i (wr_data_i),
        .re_i    (buf_re),
        .raddr_i (idx_q[BufAw-1:0]),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        abort_d   = abort_q;
        aborted_d = 1'b0;

        if (abort_i && state_q != StIdle) begin
            abort_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                if (start_i) begin
                    len_d   = eff_len;
                    gap_d   = gap_cycles_i;
                    idx_d   = '0;
                    state_d = (eff_len == '0) ? payload_exit(AppendCrlf) : StFetch;
                end
            end
            StFetch: begin
                if (abort_pend) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (xfer) begin
                    if (abort_pend) begin
                        state_d   = StIdle;
                        aborted_d = 1'b1;
                    end else if (last_byte) begin
                        state_d = payload_exit(AppendCrlf);
                    end else begin
                        idx_d   = idx_q + LenW'(1);
                        state_d = StFetch;
                    end
                end
            end
            StCr, StLf: begin
                if (xfer) begin
                    if (abort_pend) begin
                        state_d   = StIdle;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = (state_q == StCr) ? StLf : StEnd;
                    end
                end
            end
            StEnd: begin
                // The message already completed, so a late abort only cancels the repeat.
                if (repeat_en_i && !abort_pend) begin
                    state_d   = StGap;
                    gap_cnt_d = gap_q;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (abort_pend) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (gap_cnt_q == '0) begin
                    idx_d   = '0;
                    state_d = (len_q == '0) ? payload_exit(AppendCrlf) : StFetch;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        tx_data_o = 8'h00;
        unique case (state_q)
            StSend:  tx_data_o = rd_data;
            StCr:    tx_data_o = AsciiCr;
            StLf:    tx_data_o = AsciiLf;
            default: tx_data_o = 8'h00;
        endcase
    end

    assign tx_data_valid_o = (state_q == StSend) || (state_q == StCr) || (state_q == StLf);
    assign busy_o          = (state_q != StIdle);
    assign done_o          = (state_q == StEnd);
    assign aborted_o       = aborted_q;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Scoreboard bench for uart_msg_sender: expected bytes/events queued at stimulus time,
// popped by a negedge monitor on every transfer, done or aborted pulse.
module tb_uart_msg_sender;

    localparam int MaxLen  = 32;
    localparam int LenW    = 6;
    localparam int GapW    = 24;
    localparam int EvDone  = 1;
    localparam int EvAbort = 2;

    logic clk = 1'b0;
    logic reset_n, wr_en, start, repeat_en, abort;
    logic [LenW-1:0] wr_addr, msg_len;
    logic [7:0] wr_data;
    logic [GapW-1:0] gap_cycles;
    logic tx_ready, rdy_rand, rdy_force, rdy_hold;
    logic rnd = 1'b0;
    logic [7:0] tx_data, tx_data0;
    logic tx_valid, busy, done, aborted;
    logic tx_valid0, busy0, done0, aborted0;

    logic [7:0] model_buf [MaxLen];
    logic [7:0] exp_q [$];
    int ev_q [$];
    int n_checks = 0;
    int n_pass = 0;
    int n_xfer = 0;

    always #5 clk = ~clk;

    initial forever @(posedge clk) rnd <= ($urandom_range(0, 3) == 0);
    assign tx_ready = !rdy_hold && (rdy_rand ? rnd : rdy_force);

    uart_msg_sender #(.MsgMaxLen(MaxLen), .LenW(LenW), .AppendCrlf(1'b1), .GapW(GapW)) dut (
        .clk_i(clk), .reset_ni(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .msg_len_i(msg_len), .start_i(start), .repeat_en_i(repeat_en),
        .gap_cycles_i(gap_cycles), .abort_i(abort), .tx_data_o(tx_data),
        .tx_data_valid_o(tx_valid), .tx_data_ready_i(tx_ready), .busy_o(busy),
        .done_o(done), .aborted_o(aborted)
    );

    // Payload-only variant, used for the empty-message timing case.
    uart_msg_sender #(.MsgMaxLen(MaxLen), .LenW(LenW), .AppendCrlf(1'b0), .GapW(GapW)) dut0 (
        .clk_i(clk), .reset_ni(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .msg_len_i(msg_len), .start_i(start), .repeat_en_i(repeat_en),
        .gap_cycles_i(gap_cycles), .abort_i(abort), .tx_data_o(tx_data0),
        .tx_data_valid_o(tx_valid0), .tx_data_ready_i(tx_ready), .busy_o(busy0),
        .done_o(done0), .aborted_o(aborted0)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = LenW'(addr);
        wr_data = d;
        step();
        wr_en = 1'b0;
        if (addr < MaxLen) model_buf[addr] = d;
    endtask

    task automatic fill_random();
        for (int i = 0; i < MaxLen; i++) wr(i, 8'($urandom));
        wr(MaxLen + $urandom_range(0, (1 << LenW) - 1 - MaxLen), 8'($urandom));
    endtask

    function automatic void push_msg(input int len);
        int l = (len > MaxLen) ? MaxLen : len;
        for (int i = 0; i < l; i++) exp_q.push_back(model_buf[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        ev_q.push_back(EvDone);
    endfunction

    // msg_len and gap_cycles are scrambled after start: only the sampled values may matter.
    task automatic start_msg(input int len);
        msg_len = LenW'(len);
        start = 1'b1;
        step();
        start = 1'b0;
        msg_len = LenW'($urandom);
        gap_cycles = GapW'($urandom_range(0, 7));
    endtask

    task automatic wait_end(input string name, input int max, output int steps);
        steps = 0;
        while (!(done || aborted) && steps < max) begin
            step();
            steps++;
        end
        check({name, "_ended"}, int'(done || aborted), 1);
    endtask

    task automatic wait_xfer(input int target, input int max);
        int k = 0;
        while (n_xfer < target && k < max) begin
            step();
            k++;
        end
        check("xfer_reached", int'(n_xfer >= target), 1);
    endtask

    task automatic check_drained(input string name);
        check({name, "_bytes_left"}, exp_q.size(), 0);
        check({name, "_events_left"}, ev_q.size(), 0);
    endtask

    // Monitor: transfers, hold-while-valid, done/aborted pulses.
    initial begin
        logic pv = 1'b0;
        logic [7:0] pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    check("valid_held", int'(tx_valid), 1);
                    check("data_held", int'(tx_data), int'(pd));
                end
                if (tx_valid && tx_ready) begin
                    n_xfer++;
                    check("byte", int'(tx_data), exp_q.size() > 0 ? int'(exp_q.pop_front()) : -1);
                    pv = 1'b0;
                end else begin
                    pv = tx_valid;
                end
                pd = tx_data;
                if (done) check("done_event", ev_q.size() > 0 ? ev_q.pop_front() : 0, EvDone);
                if (aborted)
                    check("abort_event", ev_q.size() > 0 ? ev_q.pop_front() : 0, EvAbort);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int st, g, base, len;
        string s;
        reset_n = 1'b0; wr_en = 1'b0; start = 1'b0; repeat_en = 1'b0; abort = 1'b0;
        wr_addr = '0; wr_data = '0; msg_len = '0; gap_cycles = '0;
        rdy_rand = 1'b0; rdy_force = 1'b1; rdy_hold = 1'b0;
        step(3);
        check("rst_valid", int'(tx_valid), 0);
        check("rst_data", int'(tx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_aborted", int'(aborted), 0);
        reset_n = 1'b1;
        step();

        // Empty message: CR/LF only here, immediate done on the payload-only variant.
        push_msg(0);
        start_msg(0);
        check("len0_nocrlf_done", int'(done0), 1);
        check("len0_nocrlf_valid", int'(tx_valid0), 0);
        check("len0_cr_valid", int'(tx_valid), 1);
        check("len0_cr_data", int'(tx_data), 8'h0D);
        step();
        check("len0_nocrlf_idle", int'(busy0), 0);
        wait_end("len0", 50, st);
        step();
        check_drained("len0");

        // "Test Text" with ready held high: exact latency and message length.
        s = "Test Text";
        for (int i = 0; i < 9; i++) wr(i, s[i]);
        push_msg(9);
        start_msg(9);
        check("t1_busy", int'(busy), 1);
        check("t1_valid_n1", int'(tx_valid), 0);
        step();
        check("t1_valid_n2", int'(tx_valid), 1);
        check("t1_first_byte", int'(tx_data), int'(model_buf[0]));
        wait_end("t1", 100, st);
        check("t1_done_latency", st, 19);
        step();
        check("t1_idle", int'(busy), 0);
        check_drained("t1");

        // Sparse ready plus a long stall on byte index 3.
        rdy_rand = 1'b1;
        base = n_xfer;
        push_msg(9);
        start_msg(9);
        wait_xfer(base + 3, 300);
        rdy_hold = 1'b1;
        step(20);
        check("t2_stall_valid", int'(tx_valid), 1);
        check("t2_stall_data", int'(tx_data), int'(model_buf[3]));
        rdy_hold = 1'b0;
        wait_end("t2", 500, st);
        step();
        check_drained("t2");

        // Random contents and lengths, first round over-long (clamped to the buffer depth).
        for (int r = 0; r < 5; r++) begin
            len = (r == 0) ? 40 : int'($urandom_range(0, 40));
            fill_random();
            rdy_rand = r[0];
            push_msg(len);
            start_msg(len);
            wait_end("rand", 2000, st);
            step();
            check("rand_idle", int'(busy), 0);
        end
        check_drained("rand");

        // Auto-repeat with a 100-cycle gap, stopped by clearing repeat_en mid-message.
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        for (int i = 0; i < 3; i++) push_msg(3);
        repeat_en = 1'b1;
        gap_cycles = GapW'(100);
        start_msg(3);
        for (int i = 0; i < 3; i++) begin
            wait_end("rep", 300, st);
            if (i < 2) begin
                step(50);
                check("rep_busy_in_gap", int'(busy), 1);
                g = 50;
                while (!tx_valid && g < 300) begin
                    step();
                    g++;
                end
                check("rep_gap_len", int'(g >= 100 && g < 110), 1);
                if (i == 1) repeat_en = 1'b0;
            end
        end
        step();
        check("rep_stopped", int'(busy), 0);
        step(150);
        check("rep_still_idle", int'(busy), 0);
        check_drained("rep");

        // Abort while byte index 3 is stalled; start and writes during busy must be ignored.
        fill_random();
        for (int i = 0; i < 4; i++) exp_q.push_back(model_buf[i]);
        ev_q.push_back(EvAbort);
        base = n_xfer;
        start_msg(8);
        wait_xfer(base + 3, 100);
        rdy_force = 1'b0;
        g = 0;
        while (!tx_valid && g < 10) begin
            step();
            g++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = ~model_buf[0];
        step();
        start = 1'b0;
        wr_en = 1'b0;
        step(5);
        check("abort_pending_valid", int'(tx_valid), 1);
        check("abort_pending_data", int'(tx_data), int'(model_buf[3]));
        rdy_force = 1'b1;
        wait_end("abort", 20, st);
        check("abort_pulse", int'(aborted), 1);
        check("abort_no_done", int'(done), 0);
        step();
        check("abort_idle", int'(busy), 0);
        check_drained("abort");

        // Reset mid-message, then a fresh message from byte 0.
        push_msg(9);
        base = n_xfer;
        start_msg(9);
        wait_xfer(base + 4, 100);
        reset_n = 1'b0;
        step();
        check("mid_rst_valid", int'(tx_valid), 0);
        check("mid_rst_data", int'(tx_data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_aborted", int'(aborted), 0);
        exp_q.delete();
        ev_q.delete();
        reset_n = 1'b1;
        step();
        push_msg(9);
        start_msg(9);
        step();
        check("post_rst_first", int'(tx_data), int'(model_buf[0]));
        wait_end("post_rst", 100, st);
        step();
        check_drained("post_rst");

        step(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
